// File: rtl/rs_enc_varcheck.sv
// Systematic Reed-Solomon encoder over GF(2^M), with a check-symbol count
// chosen per codeword.
// The generator polynomial is rebuilt in hardware, one root per cycle,
// whenever the requested check count differs from the current one.
// Ports:
//   clk, reset (async, active-low)
//   sink_val/sink_sop/sink_eop/rsin/numcheck in, sink_ena out  : message side
//   source_ena in, source_val/source_sop/source_eop/rsout out  : codeword side
//   err out : one-cycle protocol error pulse
module rs_enc_varcheck #(
  parameter int CHECK     = 16,
  parameter int M         = 8,
  parameter int IRRPOL    = 285,
  parameter int GENSTART  = 0,
  parameter int ROOTSPACE = 1,
  parameter int VARCHECK  = 1,
  parameter int WIDE      = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sink_val,
  input  logic            sink_sop,
  input  logic            sink_eop,
  output logic            sink_ena,
  input  logic [M-1:0]    rsin,
  input  logic [WIDE-1:0] numcheck,
  input  logic            source_ena,
  output logic            source_val,
  output logic            source_sop,
  output logic            source_eop,
  output logic [M-1:0]    rsout,
  output logic            err
);

  localparam int CW = (M > WIDE) ? M : WIDE;
  localparam logic [M-1:0] IRR_LO = M'(IRRPOL);

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[M-1] ? ({sh[M-2:0], 1'b0} ^ IRR_LO) : {sh[M-2:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] gf_pow(input int e);
    logic [M-1:0] v;
    int unsigned  n;
    v = M'(1);
    n = unsigned'(e % ((1 << M) - 1));
    for (int unsigned i = 0; i < n; i++) v = gf_mul(v, M'(2));
    return v;
  endfunction

  localparam logic [M-1:0]           ROOT0     = gf_pow(GENSTART);
  localparam logic [M-1:0]           ROOT_STEP = gf_pow(ROOTSPACE);
  localparam logic [CHECK:0][M-1:0]  G_INIT    = ((CHECK + 1) * M)'(1);

  typedef enum logic [1:0] {S_GEN, S_IDLE, S_DATA, S_PARITY} state_e;

  state_e                  state_q, state_d;
  logic [WIDE-1:0]         ncur_q, ncur_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CHECK:0][M-1:0]   g_q, g_d;
  logic [CHECK-1:0][M-1:0] p_q, p_d;
  logic [M-1:0]            root_q, root_d;
  logic                    hold_q, hold_d, heop_q, heop_d;
  logic [M-1:0]            hsym_q, hsym_d;
  logic [M-1:0]            rsout_q, rsout_d;
  logic                    val_q, val_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;

  logic                    out_free, acc, nbad, do_sym, ssop, seop;
  logic [WIDE-1:0]         nraw, nreq;
  logic [CW-1:0]           ncur_w, maxlen, cnt_next;
  int unsigned             ncur_i;
  logic [M-1:0]            sym, fb, ptop_q;

  assign ncur_w   = CW'(ncur_q);
  assign ncur_i   = 32'(ncur_q);
  assign maxlen   = CW'((1 << M) - 1) - ncur_w;
  assign out_free = ~val_q | source_ena;
  assign sink_ena = ((state_q == S_IDLE) | ((state_q == S_DATA) & ~hold_q)) & out_free;
  assign acc      = sink_val & sink_ena;
  assign nraw     = (VARCHECK != 0) ? numcheck : WIDE'(CHECK);
  assign nbad     = (nraw == '0) | (32'(nraw) > CHECK);
  assign nreq     = nbad ? WIDE'(CHECK) : nraw;

  // Highest active parity register, p[ncur-1].
  always_comb begin
    ptop_q = '0;
    for (int unsigned j = 0; j < CHECK; j++) begin
      if (j + 1 == ncur_i) ptop_q = p_q[j];
    end
  end

  always_comb begin
    state_d  = state_q;
    ncur_d   = ncur_q;
    cnt_d    = cnt_q;
    g_d      = g_q;
    p_d      = p_q;
    root_d   = root_q;
    hold_d   = hold_q;
    heop_d   = heop_q;
    hsym_d   = hsym_q;
    rsout_d  = rsout_q;
    val_d    = val_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    err_d    = 1'b0;
    do_sym   = 1'b0;
    sym      = rsin;
    ssop     = sink_sop;
    seop     = sink_eop;
    fb       = '0;
    cnt_next = '0;

    if (out_free) begin
      val_d = 1'b0;
      sop_d = 1'b0;
      eop_d = 1'b0;
    end

    case (state_q)
      S_GEN: begin
        // Multiply g(x) by (x + root) across all coefficients at once.
        g_d[0] = gf_mul(root_q, g_q[0]);
        for (int unsigned j = 1; j <= CHECK; j++) begin
          g_d[j] = g_q[j-1] ^ gf_mul(root_q, g_q[j]);
        end
        root_d = gf_mul(root_q, ROOT_STEP);
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q + CW'(1) == ncur_w) begin
          cnt_d   = '0;
          state_d = hold_q ? S_DATA : S_IDLE;
        end
      end
      S_IDLE: begin
        if (acc) begin
          if (!sink_sop) begin
            err_d = 1'b1;
          end else begin
            err_d = nbad;
            if (nreq != ncur_q) begin
              // Park the sop symbol while the new generator is built.
              ncur_d  = nreq;
              hold_d  = 1'b1;
              hsym_d  = rsin;
              heop_d  = sink_eop;
              cnt_d   = '0;
              g_d     = G_INIT;
              root_d  = ROOT0;
              state_d = S_GEN;
            end else begin
              do_sym = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        if (hold_q) begin
          if (out_free) begin
            do_sym = 1'b1;
            sym    = hsym_q;
            ssop   = 1'b1;
            seop   = heop_q;
            hold_d = 1'b0;
          end
        end else if (acc) begin
          do_sym = 1'b1;
          if (sink_sop) err_d = 1'b1;
        end
      end
      S_PARITY: begin
        if (out_free) begin
          rsout_d = ptop_q;
          val_d   = 1'b1;
          p_d[0]  = '0;
          for (int unsigned j = 1; j < CHECK; j++) begin
            p_d[j] = (j < ncur_i) ? p_q[j-1] : '0;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == ncur_w) begin
            eop_d   = 1'b1;
            cnt_d   = '0;
            p_d     = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_GEN;
    endcase

    if (do_sym) begin
      // A sop restarts the codeword, so the old parity is ignored.
      fb     = sym ^ (ssop ? '0 : ptop_q);
      p_d[0] = gf_mul(fb, g_q[0]);
      for (int unsigned j = 1; j < CHECK; j++) begin
        if (j < ncur_i) p_d[j] = (ssop ? '0 : p_q[j-1]) ^ gf_mul(fb, g_q[j]);
        else            p_d[j] = '0;
      end
      rsout_d  = sym;
      val_d    = 1'b1;
      sop_d    = ssop;
      eop_d    = 1'b0;
      cnt_next = ssop ? CW'(1) : cnt_q + CW'(1);
      cnt_d    = cnt_next;
      state_d  = S_DATA;
      if (seop) begin
        state_d = S_PARITY;
        cnt_d   = '0;
      end else if (cnt_next == maxlen) begin
        err_d   = 1'b1;
        state_d = S_PARITY;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_GEN;
      ncur_q  <= WIDE'(CHECK);
      cnt_q   <= '0;
      g_q     <= G_INIT;
      p_q     <= '0;
      root_q  <= ROOT0;
      hold_q  <= 1'b0;
      heop_q  <= 1'b0;
      hsym_q  <= '0;
      rsout_q <= '0;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ncur_q  <= ncur_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      p_q     <= p_d;
      root_q  <= root_d;
      hold_q  <= hold_d;
      heop_q  <= heop_d;
      hsym_q  <= hsym_d;
      rsout_q <= rsout_d;
      val_q   <= val_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

  assign source_val = val_q;
  assign source_sop = sop_q;
  assign source_eop = eop_q;
  assign rsout      = rsout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rs_enc_varcheck.sv
// Bench for rs_enc_varcheck in a GF(16) configuration: codewords are checked
// against a long-division Reed-Solomon model built from log/antilog tables.
module tb_rs_enc_varcheck;
  localparam int M         = 4;
  localparam int CHECK     = 4;
  localparam int WIDE      = 3;
  localparam int IRRPOL    = 19;
  localparam int GENSTART  = 0;
  localparam int ROOTSPACE = 1;
  localparam int NN        = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sink_val = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic            source_ena = 1'b1;
  logic            sink_ena, source_val, source_sop, source_eop, err;
  logic [M-1:0]    rsin = '0;
  logic [M-1:0]    rsout;
  logic [WIDE-1:0] numcheck = '0;

  int checks = 0;
  int errors = 0;
  int bp_mode = 0;
  int err_cnt = 0;
  bit eop_seen = 1'b0;
  int got[$];
  int exp_t[0:NN-1];
  int log_t[0:NN];
  int prev_out = 0;
  bit prev_stall = 1'b0;

  rs_enc_varcheck #(
    .CHECK(CHECK), .M(M), .IRRPOL(IRRPOL), .GENSTART(GENSTART),
    .ROOTSPACE(ROOTSPACE), .VARCHECK(1), .WIDE(WIDE)
  ) dut (
    .clk(clk), .reset(rst_n),
    .sink_val(sink_val), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_ena(sink_ena), .rsin(rsin), .numcheck(numcheck),
    .source_ena(source_ena), .source_val(source_val), .source_sop(source_sop),
    .source_eop(source_eop), .rsout(rsout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got_v, input int exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  // Output collector, stall-stability monitor and err pulse counter.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 32'({source_val, source_sop, source_eop, rsout}), prev_out);
      prev_stall = source_val && !source_ena;
      prev_out   = 32'({source_val, source_sop, source_eop, rsout});
      if (source_val && source_ena) begin
        got.push_back(32'({source_sop, source_eop, rsout}));
        if (source_eop) eop_seen = 1'b1;
      end
      if (err) err_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       source_ena = 1'b1;
        1:       source_ena = ~source_ena;
        default: source_ena = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic int gfm(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % NN];
  endfunction

  // Codeword = message followed by remainder of m(x)*x^n divided by g(x).
  task automatic model_cw(input int msg[$], input int n, output int cw[$]);
    int g[0:CHECK];
    int ng[0:CHECK];
    int w[$];
    int root;
    int c;
    foreach (g[i]) g[i] = 0;
    g[0] = 1;
    for (int r = 0; r < n; r++) begin
      root  = exp_t[(GENSTART + r * ROOTSPACE) % NN];
      ng[0] = gfm(root, g[0]);
      for (int j = 1; j <= CHECK; j++) ng[j] = g[j-1] ^ gfm(root, g[j]);
      g = ng;
    end
    w = msg;
    for (int i = 0; i < n; i++) w.push_back(0);
    for (int i = 0; i < msg.size(); i++) begin
      c = w[i];
      for (int j = 0; j <= n; j++) w[i+j] = w[i+j] ^ gfm(c, g[n-j]);
    end
    cw = msg;
    for (int i = 0; i < n; i++) cw.push_back(w[msg.size() + i]);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (sink_ena) break;
      cyc++;
    end
    if (cyc >= 200) check("ready_timeout", 0, 1);
  endtask

  task automatic send_sym(input int s, input bit sop, input bit eop, input int nc);
    int budget;
    bit taken;
    budget = 0;
    taken  = 1'b0;
    @(posedge clk);
    #1;
    sink_val = 1'b1;
    rsin     = M'(s);
    sink_sop = sop;
    sink_eop = eop;
    numcheck = WIDE'(nc);
    while (!taken && budget < 200) begin
      @(negedge clk);
      taken = sink_ena;
      @(posedge clk);
      #1;
      budget++;
    end
    sink_val = 1'b0;
    sink_sop = 1'b0;
    sink_eop = 1'b0;
    if (!taken) check("accept_timeout", 0, 1);
  endtask

  task automatic run_cw(input string tag, input int msg[$], input int nc,
                        input bit last_eop, input int exp_err, input int lat);
    int cw[$];
    int n;
    int e0;
    int budget;
    int cyc;
    int exp_w;
    n = (nc < 1 || nc > CHECK) ? CHECK : nc;
    model_cw(msg, n, cw);
    got.delete();
    eop_seen = 1'b0;
    e0 = err_cnt;
    foreach (msg[i]) begin
      send_sym(msg[i], i == 0, last_eop && (i == msg.size() - 1), nc);
      if (i == 0 && lat > 0) begin
        cyc = 1;
        while (!source_val && cyc < 50) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        check({tag, "_lat"}, cyc, lat);
      end
    end
    budget = 0;
    while (!eop_seen && budget < 300) begin
      @(posedge clk);
      budget++;
    end
    if (!eop_seen) check({tag, "_eop_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_len"}, got.size(), cw.size());
    foreach (cw[i]) begin
      exp_w = ((i == 0) ? (1 << (M + 1)) : 0) | ((i == cw.size() - 1) ? (1 << M) : 0) | cw[i];
      if (i < got.size()) check({tag, "_sym"}, got[i], exp_w);
    end
    check({tag, "_err"}, err_cnt - e0, exp_err);
  endtask

  initial begin
    int v;
    int cyc;
    int cur_n;
    int e0;
    int q[$];

    v = 1;
    for (int i = 0; i < NN; i++) begin
      exp_t[i] = v;
      log_t[v] = i;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ IRRPOL;
    end

    #1;
    check("rst_sink_ena", 32'(sink_ena), 0);
    check("rst_source_val", 32'(source_val), 0);
    check("rst_flags", 32'({source_sop, source_eop}), 0);
    check("rst_rsout", 32'(rsout), 0);
    check("rst_err", 32'(err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready(cyc);
    check("gen_cycles", cyc, CHECK);

    q.delete(); q.push_back(1);
    run_cw("t1", q, 4, 1'b1, 0, 1);

    run_cw("t2", q, 2, 1'b1, 0, 4);

    q.delete();
    for (int i = 0; i < 11; i++) q.push_back(0);
    run_cw("t3", q, 4, 1'b1, 0, 6);

    bp_mode = 1;
    q.delete(); q.push_back(1);
    run_cw("t4", q, 4, 1'b1, 0, 1);
    bp_mode = 0;

    got.delete();
    e0 = err_cnt;
    send_sym(9, 1'b0, 1'b0, 4);
    repeat (3) @(posedge clk);
    #1;
    check("lone_err", err_cnt - e0, 1);
    check("lone_dropped", got.size(), 0);
    run_cw("t5", q, 0, 1'b1, 1, 1);

    send_sym(3, 1'b1, 1'b0, 4);
    send_sym(5, 1'b0, 1'b0, 4);
    send_sym(7, 1'b0, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    check("abort_val", 32'(source_val), 0);
    check("abort_rsout", 32'(rsout), 0);
    check("abort_sink_ena", 32'(sink_ena), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got.delete();
    wait_ready(cyc);
    check("regen_cycles", cyc, CHECK);
    run_cw("t6", q, 4, 1'b1, 0, 1);

    q.delete();
    for (int i = 0; i < 11; i++) q.push_back(int'($urandom_range(0, 15)));
    run_cw("maxlen", q, 4, 1'b0, 1, 1);
    cur_n = 4;

    bp_mode = 2;
    for (int t = 0; t < 10; t++) begin
      int nc;
      int neff;
      int k;
      nc   = int'($urandom_range(0, 7));
      neff = (nc == 0 || nc > CHECK) ? CHECK : nc;
      k    = int'($urandom_range(1, NN - neff));
      q.delete();
      for (int i = 0; i < k; i++) q.push_back(int'($urandom_range(0, 15)));
      run_cw("rnd", q, nc, 1'b1, (nc == 0 || nc > CHECK) ? 1 : 0,
             (neff != cur_n) ? neff + 2 : 1);
      cur_n = neff;
    end
    bp_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
